// File: rtl/uart_pkg.sv
// Shared UART definitions: drain-state encoding and launch-condition helper
// used by the transmit-side blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    START      = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_DONE_ = 2'd3
  } drain_state_e;

  // A byte may be handed to the transmitter only when one is buffered and the line is free.
  function automatic logic launch_ok(input logic has_data, input logic tx_ready);
    return has_data && tx_ready;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO: storage array, wrapping pointers and an
// occupancy counter with full/empty flags derived from it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the registered flags; a full FIFO refuses pushes even while popping.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents need no reset since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: accepts a valid/ready stream into a FIFO
// and launches one byte at a time through the transmitter's start/ready handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int CW = $clog2(DEPTH+1);

  drain_state_e         state_r;
  drain_state_e         state_s;
  logic                 tx_start_r;
  logic [DATA_BITS-1:0] tx_data_r;
  logic                 pop_s;
  logic                 push_s;
  logic [DATA_BITS-1:0] fifo_rd_data_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [CW-1:0]        fifo_count_s;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .wr_data (in_data),
    .pop     (pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // in_ready depends only on registered occupancy, never on tx_ready.
  always_comb begin
    push_s = in_valid && !fifo_full_s;
  end

  // Drain FSM; WAIT_DONE launches directly so back-to-back bytes start one cycle after ready returns.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (launch_ok(!fifo_empty_s, tx_ready)) begin
          pop_s   = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_s = WAIT_DONE_;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE_: begin
        if (launch_ok(!fifo_empty_s, tx_ready)) begin
          pop_s   = 1'b1;
          state_s = START;
        end else if (tx_ready) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE_;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, start pulse and launched-byte registers; tx_data only moves on a pop edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= {DATA_BITS{1'b0}};
    end else begin
      state_r    <= state_s;
      tx_start_r <= (state_s == START);
      if (pop_s) begin
        tx_data_r <= fifo_rd_data_s;
      end
    end
  end

  assign in_ready   = !fifo_full_s;
  assign tx_start   = tx_start_r;
  assign tx_data    = tx_data_r;
  assign fill_level = fifo_count_s;

endmodule
